// File: rtl/iic_slave_reg.sv
// iic_slave_reg: I2C target exposing an 8-bit register port with an auto-incrementing pointer.
module iic_slave_reg #(
  parameter logic [6:0] DEV_ADDR = 7'h1A
) (
  input  logic       clk_50m,
  input  logic       rst,
  input  logic       iic_sclk,
  inout  wire        iic_sdata,
  output logic [7:0] reg_addr,
  output logic       reg_wr_en,
  output logic [7:0] reg_wr_data,
  input  logic [7:0] reg_rd_data,
  output logic       busy
);
  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_CHK, IGNORE
  } state_t;
  state_t state;
  logic [2:0] scl_s, sda_s, bit_cnt;
  logic [7:0] shreg;
  logic sda_oe, rw, ld;
  logic scl_rise, scl_fall, start, stop, sda_in;
  assign iic_sdata = sda_oe ? 1'b0 : 1'bz;
  assign sda_in    = sda_s[1];
  assign scl_rise  = scl_s[1] & ~scl_s[2];
  assign scl_fall  = ~scl_s[1] & scl_s[2];
  assign start     = scl_s[1] & scl_s[2] & ~sda_s[1] & sda_s[2];
  assign stop      = scl_s[1] & scl_s[2] & sda_s[1] & ~sda_s[2];
  // Synchronizers only track the pins, so they need no reset.
  always_ff @(posedge clk_50m) begin
    scl_s <= {scl_s[1:0], iic_sclk};
    sda_s <= {sda_s[1:0], iic_sdata};
  end
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      state       <= IDLE;
      bit_cnt     <= 3'd0;
      shreg       <= 8'h00;
      sda_oe      <= 1'b0;
      rw          <= 1'b0;
      ld          <= 1'b0;
      busy        <= 1'b0;
      reg_addr    <= 8'h00;
      reg_wr_en   <= 1'b0;
      reg_wr_data <= 8'h00;
    end else begin
      reg_wr_en <= 1'b0;
      if (reg_wr_en) reg_addr <= reg_addr + 8'd1;
      if (start) begin
        state   <= ADDR;
        bit_cnt <= 3'd0;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
      end else if (stop) begin
        state  <= IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else begin
        case (state)
          ADDR, REG, WDATA: if (scl_rise) begin
            shreg   <= {shreg[6:0], sda_in};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (state == ADDR) begin
                rw    <= sda_in;
                busy  <= shreg[6:0] == DEV_ADDR;
                state <= shreg[6:0] == DEV_ADDR ? ADDR_ACK : IGNORE;
              end else if (state == REG) begin
                reg_addr <= {shreg[6:0], sda_in};
                state    <= REG_ACK;
              end else state <= WDATA_ACK;
            end
          end
          // sda_oe doubles as the phase flag: first fall drives ACK, second releases it.
          ADDR_ACK, REG_ACK, WDATA_ACK: if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe <= 1'b1;
              if (state == WDATA_ACK) begin
                reg_wr_en   <= 1'b1;
                reg_wr_data <= shreg;
              end
            end else begin
              sda_oe  <= 1'b0;
              bit_cnt <= 3'd0;
              if (state == ADDR_ACK && rw) begin
                state    <= RDATA;
                shreg    <= reg_rd_data;
                sda_oe   <= ~reg_rd_data[7];
                reg_addr <= reg_addr + 8'd1;
              end else state <= state == ADDR_ACK ? REG : WDATA;
            end
          end
          RDATA: if (scl_fall) begin
            if (ld) begin
              ld       <= 1'b0;
              shreg    <= reg_rd_data;
              sda_oe   <= ~reg_rd_data[7];
              reg_addr <= reg_addr + 8'd1;
              bit_cnt  <= 3'd0;
            end else if (bit_cnt == 3'd7) begin
              sda_oe  <= 1'b0;
              bit_cnt <= 3'd0;
              state   <= RDATA_CHK;
            end else begin
              shreg   <= {shreg[6:0], 1'b0};
              sda_oe  <= ~shreg[6];
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
          RDATA_CHK: if (scl_rise) begin
            ld    <= ~sda_in;
            state <= sda_in ? IGNORE : RDATA;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_iic_slave_reg.sv
// tb_iic_slave_reg: bus-master bench with a write scoreboard for iic_slave_reg.
module tb_iic_slave_reg;
  logic clk_50m = 1'b0, rst = 1'b1, scl = 1'b1, m_oe = 1'b0;
  wire sda;
  logic [7:0] reg_addr, reg_wr_data, reg_rd_data;
  logic reg_wr_en, busy;
  int checks = 0, failures = 0, q_ns = 625;
  int wr_cnt = 0, rd_idx = 0, low_cnt = 0, busy_cnt = 0;
  logic [15:0] obs [0:255];
  logic [15:0] exp_q [$];
  logic [7:0] exp_rd [$];
  pullup (sda);
  assign sda = m_oe ? 1'b0 : 1'bz;
  assign reg_rd_data = reg_addr ^ 8'h5A;
  always #10 clk_50m = ~clk_50m;
  iic_slave_reg dut (
    .clk_50m(clk_50m), .rst(rst), .iic_sclk(scl), .iic_sdata(sda),
    .reg_addr(reg_addr), .reg_wr_en(reg_wr_en), .reg_wr_data(reg_wr_data),
    .reg_rd_data(reg_rd_data), .busy(busy)
  );
  always @(negedge clk_50m) begin
    if (!rst && reg_wr_en === 1'b1) begin
      obs[wr_cnt[7:0]] = {reg_addr, reg_wr_data};
      wr_cnt++;
    end
    if (sda === 1'b0 && !m_oe) low_cnt++;
    if (busy === 1'b1) busy_cnt++;
  end
  task automatic send_bit(input logic b);
    m_oe = ~b;
    #(q_ns) scl = 1'b1;
    #(2 * q_ns) scl = 1'b0;
    #(q_ns);
  endtask
  task automatic bus_start();
    m_oe = 1'b0;
    #(q_ns) scl = 1'b1;
    #(q_ns) m_oe = 1'b1;
    #(q_ns) scl = 1'b0;
    #(q_ns);
  endtask
  task automatic bus_stop();
    m_oe = 1'b1;
    #(q_ns) scl = 1'b1;
    #(q_ns) m_oe = 1'b0;
    #(2 * q_ns);
  endtask
  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    m_oe = 1'b0;
    #(q_ns) scl = 1'b1;
    #(q_ns) ack = (sda === 1'b0);
    #(q_ns) scl = 1'b0;
    #(q_ns);
  endtask
  task automatic read_byte(input logic nack, output logic [7:0] b);
    m_oe = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      #(q_ns) scl = 1'b1;
      #(q_ns) b[i] = sda;
      #(q_ns) scl = 1'b0;
      #(q_ns);
    end
    send_bit(nack);
    m_oe = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk_50m);
    @(negedge clk_50m) rst = 1'b0;
    @(negedge clk_50m);
    checks++; if (sda !== 1'b1) begin failures++; $display("FAIL reset_sda: got %b expected 1 (released)", sda); end
    checks++; if (reg_wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en: got %b expected 0", reg_wr_en); end
    checks++; if (reg_addr !== 8'h00) begin failures++; $display("FAIL reset_addr: got %h expected 00", reg_addr); end
    checks++; if (reg_wr_data !== 8'h00) begin failures++; $display("FAIL reset_wr_data: got %h expected 00", reg_wr_data); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
  endtask
  task automatic test_single_write();
    logic a0, a1, a2;
    logic [15:0] e;
    q_ns = 2500;
    bus_start();
    write_byte(8'h34, a0);
    write_byte(8'h0E, a1);
    exp_q.push_back(16'h0E42);
    write_byte(8'h42, a2);
    checks++; if ({a0, a1, a2} !== 3'b111) begin failures++; $display("FAIL single_acks: got %b expected 111", {a0, a1, a2}); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy_before_stop: got %b expected 1", busy); end
    bus_stop();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_after_stop: got %b expected 0", busy); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (rd_idx >= wr_cnt) begin failures++; $display("FAIL single_write: got no write expected %h", e); end
      else begin
        if (obs[rd_idx[7:0]] !== e) begin failures++; $display("FAIL single_write: got %h expected %h", obs[rd_idx[7:0]], e); end
        rd_idx++;
      end
    end
    checks++; if (wr_cnt != rd_idx) begin failures++; $display("FAIL single_extra: got %0d writes expected %0d", wr_cnt, rd_idx); end
    rd_idx = wr_cnt;
    q_ns = 625;
  endtask
  task automatic test_mismatch();
    logic a0, a1, a2;
    int low0, busy0;
    low0 = low_cnt;
    busy0 = busy_cnt;
    bus_start();
    write_byte(8'h36, a0);
    write_byte(8'h0E, a1);
    write_byte(8'h42, a2);
    bus_stop();
    checks++; if ({a0, a1, a2} !== 3'b000) begin failures++; $display("FAIL mismatch_acks: got %b expected 000", {a0, a1, a2}); end
    checks++; if (low_cnt != low0) begin failures++; $display("FAIL mismatch_sda: got %0d low cycles expected 0", low_cnt - low0); end
    checks++; if (busy_cnt != busy0) begin failures++; $display("FAIL mismatch_busy: got %0d busy cycles expected 0", busy_cnt - busy0); end
    checks++; if (wr_cnt != rd_idx) begin failures++; $display("FAIL mismatch_writes: got %0d writes expected 0", wr_cnt - rd_idx); end
    rd_idx = wr_cnt;
  endtask
  task automatic test_burst_wrap();
    logic a;
    logic [15:0] e;
    bus_start();
    write_byte(8'h34, a);
    write_byte(8'hFE, a);
    exp_q.push_back(16'hFEA1); write_byte(8'hA1, a);
    exp_q.push_back(16'hFFA2); write_byte(8'hA2, a);
    exp_q.push_back(16'h00A3); write_byte(8'hA3, a);
    bus_stop();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (rd_idx >= wr_cnt) begin failures++; $display("FAIL burst_write: got no write expected %h", e); end
      else begin
        if (obs[rd_idx[7:0]] !== e) begin failures++; $display("FAIL burst_write: got %h expected %h", obs[rd_idx[7:0]], e); end
        rd_idx++;
      end
    end
    checks++; if (wr_cnt != rd_idx) begin failures++; $display("FAIL burst_extra: got %0d writes expected %0d", wr_cnt, rd_idx); end
    rd_idx = wr_cnt;
    checks++; if (reg_addr !== 8'h01) begin failures++; $display("FAIL burst_final_addr: got %h expected 01", reg_addr); end
  endtask
  task automatic test_read_rstart();
    logic a0, a1, a2;
    logic [7:0] b, e;
    int low0;
    bus_start();
    write_byte(8'h34, a0);
    write_byte(8'h05, a1);
    bus_start();
    write_byte(8'h35, a2);
    checks++; if ({a0, a1, a2} !== 3'b111) begin failures++; $display("FAIL read_acks: got %b expected 111", {a0, a1, a2}); end
    exp_rd.push_back(8'h05 ^ 8'h5A);
    exp_rd.push_back(8'h06 ^ 8'h5A);
    read_byte(1'b0, b);
    e = exp_rd.pop_front();
    checks++; if (b !== e) begin failures++; $display("FAIL read_byte0: got %h expected %h", b, e); end
    read_byte(1'b1, b);
    e = exp_rd.pop_front();
    checks++; if (b !== e) begin failures++; $display("FAIL read_byte1: got %h expected %h", b, e); end
    low0 = low_cnt;
    #(4 * q_ns);
    bus_stop();
    checks++; if (low_cnt != low0) begin failures++; $display("FAIL read_release_after_nack: got %0d low cycles expected 0", low_cnt - low0); end
    checks++; if (wr_cnt != rd_idx) begin failures++; $display("FAIL read_writes: got %0d writes expected 0", wr_cnt - rd_idx); end
    rd_idx = wr_cnt;
    checks++; if (reg_addr !== 8'h07) begin failures++; $display("FAIL read_final_addr: got %h expected 07", reg_addr); end
  endtask
  task automatic test_abort();
    logic a, a0, a1, a2;
    logic [15:0] e;
    logic [7:0] rb;
    rb = 8'h34;
    bus_start();
    for (int i = 7; i >= 0; i--) send_bit(rb[i]);
    m_oe = 1'b0;
    @(negedge clk_50m);
    checks++; if (sda !== 1'b0) begin failures++; $display("FAIL abort_ack_driven: got %b expected 0", sda); end
    rst = 1'b1;
    @(posedge clk_50m);
    @(negedge clk_50m);
    checks++; if (sda !== 1'b1) begin failures++; $display("FAIL abort_ack_release: got %b expected 1", sda); end
    repeat (2) @(posedge clk_50m);
    @(negedge clk_50m) rst = 1'b0;
    #(q_ns) scl = 1'b1;
    #(2 * q_ns) scl = 1'b0;
    #(q_ns);
    bus_stop();
    rb = 8'h1F;
    bus_start();
    write_byte(8'h34, a);
    checks++; if (a !== 1'b1) begin failures++; $display("FAIL abort_addr_ack: got %b expected 1", a); end
    for (int i = 7; i >= 5; i--) send_bit(rb[i]);
    m_oe = 1'b0;
    #(q_ns) scl = 1'b1;
    #(q_ns / 2);
    @(negedge clk_50m) rst = 1'b1;
    @(posedge clk_50m);
    @(negedge clk_50m);
    checks++; if (sda !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL abort_mid_reg: got sda=%b busy=%b expected sda=1 busy=0", sda, busy); end
    repeat (2) @(posedge clk_50m);
    @(negedge clk_50m) rst = 1'b0;
    #(q_ns) scl = 1'b0;
    #(q_ns);
    for (int i = 3; i >= 0; i--) send_bit(rb[i]);
    send_bit(1'b1);
    bus_stop();
    checks++; if (wr_cnt != rd_idx) begin failures++; $display("FAIL abort_no_strobe: got %0d writes expected 0", wr_cnt - rd_idx); end
    rd_idx = wr_cnt;
    bus_start();
    write_byte(8'h34, a0);
    write_byte(8'h10, a1);
    exp_q.push_back(16'h1077);
    write_byte(8'h77, a2);
    bus_stop();
    checks++; if ({a0, a1, a2} !== 3'b111) begin failures++; $display("FAIL abort_recover_acks: got %b expected 111", {a0, a1, a2}); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (rd_idx >= wr_cnt) begin failures++; $display("FAIL abort_recover_write: got no write expected %h", e); end
      else begin
        if (obs[rd_idx[7:0]] !== e) begin failures++; $display("FAIL abort_recover_write: got %h expected %h", obs[rd_idx[7:0]], e); end
        rd_idx++;
      end
    end
    checks++; if (wr_cnt != rd_idx) begin failures++; $display("FAIL abort_recover_extra: got %0d writes expected %0d", wr_cnt, rd_idx); end
    rd_idx = wr_cnt;
    checks++; if (reg_addr !== 8'h11) begin failures++; $display("FAIL abort_final_addr: got %h expected 11", reg_addr); end
  endtask
  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
  initial begin
    test_reset();
    test_single_write();
    test_mismatch();
    test_burst_wrap();
    test_read_rstart();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/iic_slave_reg.md
# iic_slave_reg

I2C responder (target) that emulates a codec-style 8-bit register port on the FPGA side of the bus. It decodes START/STOP, matches a 7-bit device address, and ACKs. Write frames (device address, register pointer, data bytes) become register-write pulses, with the pointer auto-incrementing. Read frames return bytes supplied by the register file. It is the bus-side counterpart of the team's 3-byte I2C write master, and is used both as a loopback target for that master and as a configuration slave.

## Interface
Parameters:
- DEV_ADDR, 7'h1A, 7-bit device address; write byte 0x34, read byte 0x35.

Ports:
- clk_50m  input  1  system clock, 50 MHz; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- iic_sclk  input  1  bus clock from master, asynchronous.
- iic_sdata  inout  1  open-drain data; driven 0 or released (z), never driven 1.
- reg_addr  output  8  current register pointer.
- reg_wr_en  output  1  one-cycle write strobe.
- reg_wr_data  output  8  write data, valid while reg_wr_en=1.
- reg_rd_data  input  8  read data for reg_addr; combinational from the register file.
- busy  output  1  high from address match until STOP, START or reset.

## Operation
- SCL and SDA pass through 2-flop synchronizers, then a third register for edge detect. Derived single-cycle events:
  - scl_rise, scl_fall.
  - start: SDA falls while SCL is high.
  - stop: SDA rises while SCL is high.
- States: IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_CHK, IGNORE.
- start (any state, including repeated START): go to ADDR, clear bit counter, release SDA, busy=0. Register pointer is kept.
- stop (any state): go to IDLE, release SDA, busy=0.
- Shifting: bits are shifted MSB first on scl_rise. The bit counter runs 0..7; the byte completes on the 8th scl_rise.
- ADDR complete, upper 7 bits match DEV_ADDR: busy=1.
  - On the next scl_fall, drive SDA low (ACK).
  - If R/W=0: go to ADDR_ACK, then REG.
  - If R/W=1: go to ADDR_ACK, then RDATA.
- ADDR complete, no match: go to IGNORE. SDA is never driven; stay until start or stop.
- REG complete: pointer <= received byte. ACK as above, then go to WDATA.
- WDATA complete: on the ACK-driving scl_fall:
  - reg_wr_en=1 for one cycle, reg_wr_data=byte, reg_addr=pointer.
  - Next cycle: pointer+1, wrapping 0xFF -> 0x00.
  - ACK, then WDATA again (unbounded burst).
- ACK release: SDA is released on the scl_fall that ends the 9th clock.
- RDATA load: on the scl_fall ending the address ACK (or ending a master ACK), capture reg_rd_data into the shift register, increment the pointer, and present the MSB.
  - Each following scl_fall presents the next bit. A 1 bit is released; a 0 bit is driven low.
  - After the 8th bit, the following scl_fall releases SDA and the state goes to RDATA_CHK.
- RDATA_CHK: sample SDA on scl_rise.
  - 0 (master ACK): go to RDATA and load the next byte on the following scl_fall.
  - 1 (master NACK): go to IGNORE.
- START during a byte discards the partial byte; no write strobe is issued.

## Timing
- Reset values:
  - SDA released (z); reg_wr_en=0; reg_wr_data=0x00; reg_addr=0x00; busy=0.
  - State IDLE; bit counter 0; shift register 0.
- Reset wins over all bus events in the same cycle. A reset mid-frame releases SDA on the next clk_50m edge.
- Detection latency: 3 clk_50m cycles from a pin edge to its event.
- SDA changes 1 cycle after scl_fall, giving about 80 ns hold after the physical SCL fall. This is valid for SCL up to 400 kHz.
- reg_wr_en is asserted 1 cycle after the scl_fall following the 8th data bit.
- reg_rd_data must be stable within 1 cycle of a reg_addr change.
- If scl_rise/scl_fall coincide with start/stop in the same cycle, start/stop takes priority.

## Test plan
- Reset: hold rst 3 cycles mid-bus-idle -> iic_sdata=z, reg_wr_en=0, reg_addr=0x00, busy=0.
- Single write: master sends 0x34, 0x0E, 0x42, STOP at 100 kHz -> SDA low on all three 9th clocks; exactly one reg_wr_en pulse with reg_addr=0x0E, reg_wr_data=0x42; busy falls at STOP.
- Address mismatch: 0x36, 0x0E, 0x42 -> SDA never driven low, no reg_wr_en, busy stays 0.
- Burst with wrap: 0x34, 0xFE, 0xA1, 0xA2, 0xA3 -> writes (0xFE, 0xA1), (0xFF, 0xA2), (0x00, 0xA3); final reg_addr=0x01.
- Read with repeated START: regfile returns addr^0x5A. Master sends 0x34, 0x05, Sr, 0x35, reads 2 bytes (ACK, then NACK), STOP -> bytes 0x5F, 0x5C; no reg_wr_en; SDA released after NACK.
- Abort: assert rst during the 4th bit of the reg byte -> SDA released next cycle, no write strobe; a following full write frame completes normally.
